mc_control_unit: RTL and testbench

- Parametrised multicycle RV32I control FSM; next generation of the core's controller.
- Adds full branch set, JALR, LUI/AUIPC, shifts/XOR/SLTU, a memory ready handshake with wait states, and a sticky illegal-instruction trap.
- Sits between the instruction register and the datapath.
- Drives datapath mux selects and write strobes from the opcode, the ALU flags and its internal state.

---
 rtl/mc_control_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// ============================================================================
//  Module   : mc_control_unit
//  Brief    : Multicycle RV32I control FSM driving datapath selects/strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mc_control_unit #(
  parameter int FULL_ISA      = 1,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessS,
  input  logic       LessU,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR  = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECR   = 4'd6,  S_EXECI   = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL     = 4'd10, S_JALR    = 4'd11,
    S_JALRLINK = 4'd12, S_LUI      = 4'd13, S_AUIPC   = 4'd14, S_TRAP    = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ok;
  logic       w_alu_ok;
  logic       w_br_ok;
  logic       w_taken;
  logic [3:0] w_alu_dec;
  logic       w_memreq, w_pcwrite, w_memwrite, w_irwrite, w_regwrite;

  assign w_mem_ok = mem_ready | (MEM_HANDSHAKE == 0);

  // Subset core only implements add/sub/and/or/slt and beq.
  assign w_alu_ok = (FULL_ISA != 0) ||
                    !(funct3 == 3'b001 || funct3 == 3'b011 ||
                      funct3 == 3'b100 || funct3 == 3'b101);
  assign w_br_ok  = (funct3 != 3'b010) && (funct3 != 3'b011) &&
                    ((FULL_ISA != 0) || (funct3 == 3'b000));

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = LessS;
      3'b101:  w_taken = ~LessS;
      3'b110:  w_taken = LessU;
      3'b111:  w_taken = ~LessU;
      default: w_taken = 1'b0;
    endcase
  end

  // op[5] separates R-type (sub/sra capable) from I-type on funct3 000.
  always_comb begin
    w_alu_dec = 4'd0;
    case (funct3)
      3'b000:  w_alu_dec = (op[5] && funct7b5) ? 4'd1 : 4'd0;
      3'b001:  w_alu_dec = 4'd7;
      3'b010:  w_alu_dec = 4'd5;
      3'b011:  w_alu_dec = 4'd6;
      3'b100:  w_alu_dec = 4'd4;
      3'b101:  w_alu_dec = funct7b5 ? 4'd9 : 4'd8;
      3'b110:  w_alu_dec = 4'd3;
      default: w_alu_dec = 4'd2;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_memreq   = 1'b0;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 4'd0;
    case (r_state)
      S_FETCH: begin
        w_memreq  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = w_mem_ok;
        w_pcwrite = w_mem_ok;
        if (w_mem_ok) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == 7'b1101111) ? 3'b011 : 3'b010;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = w_alu_ok ? S_EXECR : S_TRAP;
          7'b0010011: w_next = w_alu_ok ? S_EXECI : S_TRAP;
          7'b1100011: w_next = w_br_ok ? S_BRANCH : S_TRAP;
          7'b1101111: w_next = S_JAL;
          7'b1100111: w_next = (FULL_ISA != 0) ? S_JALR  : S_TRAP;
          7'b0110111: w_next = (FULL_ISA != 0) ? S_LUI   : S_TRAP;
          7'b0010111: w_next = (FULL_ISA != 0) ? S_AUIPC : S_TRAP;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b001 : 3'b000;
        w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_memreq = 1'b1;
        AdrSrc   = 1'b1;
        if (w_mem_ok) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_memreq   = 1'b1;
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        if (w_mem_ok) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_dec;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_dec;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 4'd1;
        w_pcwrite  = w_taken;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_LUI, S_AUIPC: begin
        ALUSrcA    = (r_state == S_LUI) ? 2'b11 : 2'b01;
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        ResultSrc  = 2'b10;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_TRAP;
    endcase
  end

  assign MemReq   = w_memreq   & ~reset;
  assign PCWrite  = w_pcwrite  & ~reset;
  assign MemWrite = w_memwrite & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;
  assign RegWrite = w_regwrite & ~reset;
  assign illegal  = (r_state == S_TRAP) & ~reset;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
//  Module   : tb_mc_control_unit
//  Brief    : Scoreboard bench: full-ISA and subset controllers, directed vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, LessS, LessU, mem_ready;

  always #5 clk = ~clk;

  logic       MemReq_a, PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a, illegal_a;
  logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a;
  logic [2:0] ImmSrc_a;
  logic [3:0] ALUControl_a, state_a;
  logic       MemReq_b, PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, illegal_b;
  logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b;
  logic [2:0] ImmSrc_b;
  logic [3:0] ALUControl_b, state_b;

  mc_control_unit #(.FULL_ISA(1), .MEM_HANDSHAKE(1)) dut_full (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessS(LessS), .LessU(LessU), .mem_ready(mem_ready),
    .MemReq(MemReq_a), .PCWrite(PCWrite_a), .AdrSrc(AdrSrc_a), .MemWrite(MemWrite_a),
    .IRWrite(IRWrite_a), .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
    .ImmSrc(ImmSrc_a), .ALUControl(ALUControl_a), .RegWrite(RegWrite_a),
    .illegal(illegal_a), .state(state_a)
  );

  mc_control_unit #(.FULL_ISA(0), .MEM_HANDSHAKE(1)) dut_sub (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessS(LessS), .LessU(LessU), .mem_ready(mem_ready),
    .MemReq(MemReq_b), .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b),
    .IRWrite(IRWrite_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
    .ImmSrc(ImmSrc_b), .ALUControl(ALUControl_b), .RegWrite(RegWrite_b),
    .illegal(illegal_b), .state(state_b)
  );

  // {state, MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, ResultSrc, A, B, Imm, ALU}
  logic [23:0] act_a, act_b;
  assign act_a = {state_a, MemReq_a, PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a,
                  illegal_a, ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, ALUControl_a};
  assign act_b = {state_b, MemReq_b, PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b,
                  illegal_b, ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUControl_b};

  typedef struct {
    string       name;
    bit          which;
    logic [23:0] exp;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Strobe groups {MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal}
  localparam logic [6:0] c_NONE  = 7'b0000000;
  localparam logic [6:0] c_FET   = 7'b1000000;
  localparam logic [6:0] c_FETOK = 7'b1100100;
  localparam logic [6:0] c_MRD   = 7'b1010000;
  localparam logic [6:0] c_MWR   = 7'b1011000;
  localparam logic [6:0] c_RW    = 7'b0000010;
  localparam logic [6:0] c_PCW   = 7'b0100000;
  localparam logic [6:0] c_ILL   = 7'b0000001;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      ent_t        e;
      logic [23:0] act;
      e   = q.pop_front();
      act = e.which ? act_b : act_a;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got st=%0d strb=%b rs=%b a=%b b=%b imm=%b alu=%0d, expected st=%0d strb=%b rs=%b a=%b b=%b imm=%b alu=%0d",
                 e.name, act[23:20], act[19:13], act[12:11], act[10:9], act[8:7], act[6:4], act[3:0],
                 e.exp[23:20], e.exp[19:13], e.exp[12:11], e.exp[10:9], e.exp[8:7], e.exp[6:4], e.exp[3:0]);
      end
    end
  end

  task automatic push(input string nm, input bit w, input logic [3:0] st, input logic [6:0] s,
                      input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] im, input logic [3:0] alu);
    ent_t e;
    e.name  = nm;
    e.which = w;
    e.exp   = {st, s, rs, a, b, im, alu};
    q.push_back(e);
  endtask

  task automatic drv(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic ls, input logic lu, input logic mr);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; LessS = ls; LessU = lu; mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH with memory ready, then DECODE (branch-immediate target)
  task automatic fetch_decode(input string nm);
    push({nm, "_fetch"}, 1'b0, 4'd0, c_FETOK, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();
    push({nm, "_decode"}, 1'b0, 4'd1, c_NONE, 2'b00, 2'b01, 2'b01, 3'b010, 4'd0); tick();
  endtask

  initial begin
    reset = 1'b1;
    drv(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      push("reset_a", 1'b0, 4'd0, c_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
      push("reset_b", 1'b1, 4'd0, c_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
      tick();
    end
    reset = 1'b0;

    // R-type sub
    fetch_decode("sub");
    push("sub_execr", 1'b0, 4'd6, c_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1); tick();
    push("sub_aluwb", 1'b0, 4'd8, c_RW,   2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();

    // lw with two wait states in FETCH and in MEMREAD
    drv(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      push("lw_fetch_wait", 1'b0, 4'd0, c_FET, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();
    end
    mem_ready = 1'b1;
    fetch_decode("lw");
    push("lw_memadr", 1'b0, 4'd2, c_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0); tick();
    mem_ready = 1'b0;
    repeat (2) begin
      push("lw_memread_wait", 1'b0, 4'd3, c_MRD, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();
    end
    mem_ready = 1'b1;
    push("lw_memread_ok", 1'b0, 4'd3, c_MRD,  2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();
    push("lw_memwb",      1'b0, 4'd4, c_RW,   2'b01, 2'b00, 2'b00, 3'b000, 4'd0); tick();

    // sw with one wait state in MEMWRITE
    drv(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_decode("sw");
    push("sw_memadr", 1'b0, 4'd2, c_NONE, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0); tick();
    mem_ready = 1'b0;
    push("sw_memwrite_wait", 1'b0, 4'd5, c_MWR, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();
    mem_ready = 1'b1;
    push("sw_memwrite_ok",   1'b0, 4'd5, c_MWR, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();

    // Branches: bltu taken / not taken, bne with Zero
    drv(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    fetch_decode("bltu_t");
    push("bltu_taken", 1'b0, 4'd9, c_PCW, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1); tick();
    drv(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fetch_decode("bltu_n");
    push("bltu_not", 1'b0, 4'd9, c_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1); tick();
    drv(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    fetch_decode("bne");
    push("bne_zero", 1'b0, 4'd9, c_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1); tick();

    // srai: I-type funct3 101 with funct7b5 selects sra
    drv(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_decode("srai");
    push("srai_execi", 1'b0, 4'd7, c_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 4'd9); tick();
    push("srai_aluwb", 1'b0, 4'd8, c_RW,   2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();

    // jal: J immediate in DECODE
    drv(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push("jal_fetch",  1'b0, 4'd0,  c_FETOK, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();
    push("jal_decode", 1'b0, 4'd1,  c_NONE,  2'b00, 2'b01, 2'b01, 3'b011, 4'd0); tick();
    push("jal_jal",    1'b0, 4'd10, c_PCW,   2'b00, 2'b01, 2'b10, 3'b000, 4'd0); tick();
    push("jal_aluwb",  1'b0, 4'd8,  c_RW,    2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();

    // jalr
    drv(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_decode("jalr");
    push("jalr_jalr", 1'b0, 4'd11, c_PCW, 2'b10, 2'b10, 2'b01, 3'b000, 4'd0); tick();
    push("jalr_link", 1'b0, 4'd12, c_RW,  2'b10, 2'b01, 2'b10, 3'b000, 4'd0); tick();

    // Unknown opcode traps and stays trapped with mem_ready high
    drv(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_decode("badop");
    repeat (10) begin
      push("badop_trap", 1'b0, 4'd15, c_ILL, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();
    end
    reset = 1'b1;
    push("trap_reset_a", 1'b0, 4'd0, c_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
    push("trap_reset_b", 1'b1, 4'd0, c_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
    tick();
    reset = 1'b0;

    // lui: executes on the full core, traps on the subset core
    drv(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push("lui_fetch_b",  1'b1, 4'd0, c_FETOK, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
    push("lui_fetch_a",  1'b0, 4'd0, c_FETOK, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();
    push("lui_decode_b", 1'b1, 4'd1, c_NONE,  2'b00, 2'b01, 2'b01, 3'b010, 4'd0);
    push("lui_decode_a", 1'b0, 4'd1, c_NONE,  2'b00, 2'b01, 2'b01, 3'b010, 4'd0); tick();
    push("lui_exec_a",   1'b0, 4'd13, c_RW,   2'b10, 2'b11, 2'b01, 3'b100, 4'd0);
    repeat (10) begin
      push("lui_subset_trap", 1'b1, 4'd15, c_ILL, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0); tick();
    end
    reset = 1'b1;
    push("subset_reset", 1'b1, 4'd0, c_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    push("subset_fetch_after", 1'b1, 4'd0, c_FET, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0); tick();

    tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
